drain_requant_unit: RTL and testbench
=====================================

// Module: drain_requant_unit
// PURPOSE
//  Downstream of global_controller; consumes the systolic array's accumulator rows while ctrl_drain_en is high.
//  Requantizes each ACC_W lane to signed OUT_W using a rounding arithmetic right shift and saturation.
//  Buffers the results in a FIFO and streams them out over AXI-Stream, one array row per beat.
//  Reports tile completion back to the controller.
// PARAMETERS
//  ARRAY_COLS  16   lanes per row (systolic array width)
//  ACC_W       32   signed accumulator width per lane
//  OUT_W       8    signed output width per lane
//  FIFO_DEPTH  32   row-entries in output FIFO (power of 2, >=4)
// PORTS
//  clk            in   1                  system clock
//  rst_n          in   1                  async active-low reset
//  ctrl_drain_en  in   1                  drain phase enable from global_controller
//  cfg_rows       in   16                 result rows per tile
//  cfg_shift      in   5                  requant right-shift amount
//  acc_valid      in   1                  acc_data row valid
//  acc_data       in   ARRAY_COLS*ACC_W   accumulator row; lane i = bits[i*ACC_W +: ACC_W]
//  acc_ready      out  1                  unit can accept a row this cycle
//  m_axis_tdata   out  ARRAY_COLS*OUT_W   requantized row; lane i = bits[i*OUT_W +: OUT_W]
//  m_axis_tvalid  out  1                  stream valid
//  m_axis_tready  in   1                  stream ready
//  m_axis_tlast   out  1                  last row of tile
//  drain_busy     out  1                  state != IDLE
//  drain_done     out  1                  1-cycle pulse: tile fully streamed
//  overflow_err   out  1                  sticky: row arrived while FIFO full
// BEHAVIOUR
//  Reset (async): all outputs 0; FSM=IDLE; FIFO empty; counters 0; overflow_err=0.
//  FSM states: IDLE, COLLECT, FLUSH, DONE.
//   IDLE->COLLECT when ctrl_drain_en=1 and cfg_rows!=0; latches cfg_rows/cfg_shift.
//   IDLE->DONE when ctrl_drain_en=1 and cfg_rows==0 (no beats emitted).
//   COLLECT->FLUSH in the cycle after the cfg_rows-th row is accepted.
//   FLUSH->DONE once out_cnt==cfg_rows (last tlast beat handshaken).
//   DONE->IDLE unconditionally; drain_done=1 only in DONE.
//   ctrl_drain_en is ignored outside IDLE; deasserting it mid-tile does not abort.
//  Accept: row accepted iff state==COLLECT && acc_valid && acc_ready.
//   acc_ready = (state==COLLECT) && (free FIFO slots - rows in pipeline > 0).
//   acc_valid is ignored outside COLLECT.
//  Requant pipeline, 2 stages, per lane:
//   S1: for s>0, t = (acc + (1<<(s-1))) >>> s, computed in ACC_W+1 bits (no wrap); for s==0, t = acc.
//   S2: saturate t to [-(2^(OUT_W-1)), 2^(OUT_W-1)-1].
//   Row accepted at cycle N is written to the FIFO at end of N+2.
//   tvalid is asserted no earlier than N+3 (FIFO read is first-word-fall-through, registered).
//  AXIS rules:
//   tdata/tlast are held stable while tvalid && !tready; beat transfers on tvalid&&tready.
//   tlast=1 on the beat where out_cnt==cfg_rows-1.
//  Boundary cases:
//   FIFO full at pipeline write (only if upstream ignores acc_ready): drop the row, set overflow_err.
//   A dropped row still counts toward the tile; overflow_err is cleared only by reset.
//   Simultaneous FIFO push and pop when full or empty: both occur; occupancy unchanged.
//   Pointers wrap modulo FIFO_DEPTH.
//   Reset asserted mid-tile: immediate return to reset state; partial data is discarded.
// TESTING
//  1 cfg_rows=4, shift=0, lanes={1,-1,127,-128}, tready=1 -> 4 beats identical, tlast on beat 4, drain_done 1 cycle after.
//  2 shift=4, acc=24 -> 2 (round half-up: 24+8=32>>4); acc=-24 -> -1; acc=7 -> 0; acc=8 -> 1.
//  3 shift=0, acc=1000 -> 127; acc=-70000 -> -128; acc=0x7FFFFFFF with shift=31 -> 1 (no wrap in S1).
//  4 cfg_rows=40, FIFO_DEPTH=32, tready=0 for 100 cycles -> acc_ready drops after 32 rows in FIFO+pipe, overflow_err=0, tdata stable;
//    then tready=1 -> all 40 beats delivered in order, tlast on beat 40.
//  5 force acc_valid=1 ignoring acc_ready with FIFO full -> overflow_err=1 and stays 1; tile still ends with drain_done after cfg_rows counted.
//  6 cfg_rows=0 -> IDLE->DONE->IDLE, drain_done pulse, no tvalid; rst_n low mid-FLUSH -> all outputs 0 next edge, FIFO empty.

Source files
------------

// File: rtl/drain_requant_unit.sv
// Drain/requantization unit: takes accumulator rows from the systolic array, rounds, shifts and
// saturates each lane, buffers the rows in a FIFO and streams them out over AXI-Stream.
module drain_requant_unit #(
    parameter int unsigned ARRAY_COLS = 16,
    parameter int unsigned ACC_W      = 32,
    parameter int unsigned OUT_W      = 8,
    parameter int unsigned FIFO_DEPTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ctrl_drain_en,
    input  logic [15:0]                   cfg_rows,
    input  logic [4:0]                    cfg_shift,
    input  logic                          acc_valid,
    input  logic [ARRAY_COLS*ACC_W-1:0]   acc_data,
    output logic                          acc_ready,
    output logic [ARRAY_COLS*OUT_W-1:0]   m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          drain_busy,
    output logic                          drain_done,
    output logic                          overflow_err
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned T_W   = ACC_W + 1;
    localparam int unsigned ROW_W = ARRAY_COLS * OUT_W;
    localparam logic signed [T_W-1:0] SAT_MAX = T_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [T_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {StIdle, StCollect, StFlush, StDone} state_e;

    state_e state_q, state_d;
    logic [15:0] rows_q, in_cnt_q, out_cnt_q, out_cnt_d;
    logic [4:0]  shift_q;
    logic        overflow_q;

    logic                       s1_valid_q, s2_valid_q;
    logic [ARRAY_COLS*T_W-1:0]  s1_data_q, s1_next;
    logic [ROW_W-1:0]           s2_data_q, s2_next;

    logic [ROW_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, in_flight;

    logic fifo_full, accept, drop, take, push, pop, start;

    // Round half-up then arithmetic shift, one bit wider than the accumulator so it never wraps.
    function automatic logic signed [T_W-1:0] round_shift(input logic [ACC_W-1:0] acc,
                                                          input logic [4:0] s);
        logic signed [T_W-1:0] ext, rnd, sum;
        ext = {acc[ACC_W-1], acc};
        rnd = (s == 5'd0) ? '0 : (T_W'(1) << (s - 5'd1));
        sum = ext + rnd;
        return sum >>> s;
    endfunction

    function automatic logic [OUT_W-1:0] saturate(input logic signed [T_W-1:0] t);
        if (t > SAT_MAX) begin
            return SAT_MAX[OUT_W-1:0];
        end else if (t < SAT_MIN) begin
            return SAT_MIN[OUT_W-1:0];
        end
        return t[OUT_W-1:0];
    endfunction

    assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
    assign in_flight = count_q + CNT_W'(s1_valid_q) + CNT_W'(s2_valid_q);
    assign acc_ready = (state_q == StCollect) && (in_flight < CNT_W'(FIFO_DEPTH));
    assign accept    = (state_q == StCollect) && acc_valid && acc_ready;
    // A row forced in while the FIFO is full is lost but still consumes a tile slot.
    assign drop      = (state_q == StCollect) && acc_valid && !acc_ready && fifo_full;
    assign take      = accept || drop;
    assign push      = s2_valid_q;
    assign pop       = m_axis_tvalid && m_axis_tready;
    assign start     = (state_q == StIdle) && ctrl_drain_en;
    assign out_cnt_d = out_cnt_q + 16'(pop) + 16'(drop);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (ctrl_drain_en) begin
                    state_d = (cfg_rows == 16'd0) ? StDone : StCollect;
                end
            end
            StCollect: begin
                if (take && (in_cnt_q + 16'd1 == rows_q)) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                if (out_cnt_d == rows_q) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            rows_q     <= '0;
            shift_q    <= '0;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start) begin
                rows_q    <= cfg_rows;
                shift_q   <= cfg_shift;
                in_cnt_q  <= '0;
                out_cnt_q <= '0;
            end else begin
                in_cnt_q  <= in_cnt_q + 16'(take);
                out_cnt_q <= out_cnt_d;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_comb begin
        s1_next = '0;
        s2_next = '0;
        for (int i = 0; i < int'(ARRAY_COLS); i++) begin
            s1_next[i*T_W +: T_W]     = round_shift(acc_data[i*ACC_W +: ACC_W], shift_q);
            s2_next[i*OUT_W +: OUT_W] = saturate(s1_data_q[i*T_W +: T_W]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s2_data_q  <= '0;
        end else begin
            s1_valid_q <= accept;
            s2_valid_q <= s1_valid_q;
            if (accept) begin
                s1_data_q <= s1_next;
            end
            if (s1_valid_q) begin
                s2_data_q <= s2_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= s2_data_q;
        end
    end

    assign m_axis_tvalid = (count_q != '0);
    assign m_axis_tdata  = m_axis_tvalid ? mem[rd_ptr_q] : '0;
    assign m_axis_tlast  = m_axis_tvalid && (out_cnt_q == rows_q - 16'd1);
    assign drain_busy    = (state_q != StIdle);
    assign drain_done    = (state_q == StDone);
    assign overflow_err  = overflow_q;

endmodule

// File: tb/tb_drain_requant_unit.sv
// Directed bench for drain_requant_unit: requant arithmetic, AXIS backpressure, overflow, reset.
module tb_drain_requant_unit;

    localparam int COLS  = 16;
    localparam int ACC_W = 32;
    localparam int OUT_W = 8;
    localparam int DEPTH = 32;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    ctrl_drain_en = 1'b0;
    logic [15:0]             cfg_rows = '0;
    logic [4:0]              cfg_shift = '0;
    logic                    acc_valid = 1'b0;
    logic [COLS*ACC_W-1:0]   acc_data = '0;
    logic                    acc_ready;
    logic [COLS*OUT_W-1:0]   m_axis_tdata;
    logic                    m_axis_tvalid;
    logic                    m_axis_tready = 1'b0;
    logic                    m_axis_tlast;
    logic                    drain_busy;
    logic                    drain_done;
    logic                    overflow_err;

    int checks = 0;
    int failures = 0;
    int mode = 0;
    int acc_pat[4];
    int exp_pat[4];

    drain_requant_unit #(
        .ARRAY_COLS(COLS), .ACC_W(ACC_W), .OUT_W(OUT_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ctrl_drain_en(ctrl_drain_en), .cfg_rows(cfg_rows),
        .cfg_shift(cfg_shift), .acc_valid(acc_valid), .acc_data(acc_data),
        .acc_ready(acc_ready), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .drain_busy(drain_busy),
        .drain_done(drain_done), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: lane i uses acc_pat[i%4]; mode 1: ramp r*3-i, which passes through unchanged at s=0
    function automatic logic [COLS*ACC_W-1:0] row_acc(input int r);
        logic [COLS*ACC_W-1:0] row;
        int v;
        row = '0;
        for (int i = 0; i < COLS; i++) begin
            v = (mode == 0) ? acc_pat[i % 4] : r * 3 - i;
            row[i*ACC_W +: ACC_W] = v;
        end
        return row;
    endfunction

    function automatic logic [127:0] row_exp(input int r);
        logic [127:0] row;
        int v;
        row = '0;
        for (int i = 0; i < COLS; i++) begin
            v = (mode == 0) ? exp_pat[i % 4] : r * 3 - i;
            row[i*OUT_W +: OUT_W] = v[7:0];
        end
        return row;
    endfunction

    task automatic start_tile(input int rows, input int shift);
        @(negedge clk);
        cfg_rows      = 16'(rows);
        cfg_shift     = 5'(shift);
        ctrl_drain_en = 1'b1;
        @(negedge clk);
        ctrl_drain_en = 1'b0;
    endtask

    task automatic run_tile(input string tag, input int rows, input int shift, input int stall,
                            input bit force_v, input int exp_beats, input bit exp_ovf);
        int sent = 0;
        int beat = 0;
        int cyc = 0;
        start_tile(rows, shift);
        chk({tag, ":busy"}, 128'(drain_busy), 128'(1));
        while (beat < exp_beats && cyc < 2000) begin
            m_axis_tready = (cyc >= stall);
            if (stall > 0 && cyc == stall) begin
                chk({tag, ":stall_ready"}, 128'(acc_ready), 128'(0));
                chk({tag, ":stall_sent"}, 128'(sent), 128'((rows < DEPTH) ? rows : DEPTH));
                chk({tag, ":stall_ovf"}, 128'(overflow_err), 128'(exp_ovf));
                chk({tag, ":stall_data"}, 128'(m_axis_tdata), row_exp(0));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                chk({tag, ":data"}, 128'(m_axis_tdata), row_exp(beat));
                chk({tag, ":tlast"}, 128'(m_axis_tlast), 128'(beat == exp_beats - 1));
                beat++;
            end
            if (sent < rows && acc_ready) begin
                acc_valid = 1'b1;
                acc_data  = row_acc(sent);
                sent++;
            end else begin
                acc_valid = force_v;
                acc_data  = force_v ? row_acc(sent) : '0;
            end
            cyc++;
            @(negedge clk);
        end
        acc_valid = 1'b0;
        chk({tag, ":beats"}, 128'(beat), 128'(exp_beats));
        chk({tag, ":done"}, 128'(drain_done), 128'(1));
        chk({tag, ":ovf"}, 128'(overflow_err), 128'(exp_ovf));
        @(negedge clk);
        chk({tag, ":done_pulse"}, 128'(drain_done), 128'(0));
        chk({tag, ":idle"}, 128'(drain_busy), 128'(0));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_tvalid", 128'(m_axis_tvalid), 128'(0));
        chk("rst_ready", 128'(acc_ready), 128'(0));
        chk("rst_busy", 128'(drain_busy), 128'(0));
        chk("rst_done", 128'(drain_done), 128'(0));
        chk("rst_ovf", 128'(overflow_err), 128'(0));
        chk("rst_tdata", 128'(m_axis_tdata), 128'(0));
        rst_n = 1'b1;

        // passthrough at shift 0
        mode = 0;
        acc_pat = '{1, -1, 127, -128};
        exp_pat = '{1, -1, 127, -128};
        run_tile("t1", 4, 0, 0, 1'b0, 4, 1'b0);

        // round half-up at shift 4
        acc_pat = '{24, -24, 7, 8};
        exp_pat = '{2, -1, 0, 1};
        run_tile("t2", 2, 4, 0, 1'b0, 2, 1'b0);

        // saturation at shift 0
        acc_pat = '{1000, -70000, 0, -5};
        exp_pat = '{127, -128, 0, -5};
        run_tile("t3a", 2, 0, 0, 1'b0, 2, 1'b0);

        // shift 31 must not wrap the rounding add
        acc_pat = '{int'(32'h7FFFFFFF), int'(32'h80000000), int'(32'h40000000),
                    int'(32'h3FFFFFFF)};
        exp_pat = '{1, -1, 1, 0};
        run_tile("t3b", 1, 31, 0, 1'b0, 1, 1'b0);

        // backpressure: 40 rows, sink stalled 100 cycles
        mode = 1;
        run_tile("t4", 40, 0, 100, 1'b0, 40, 1'b0);

        // upstream ignores acc_ready while FIFO full: 8 rows dropped, 32 delivered
        run_tile("t5", 40, 0, 60, 1'b1, 32, 1'b1);
        repeat (3) @(negedge clk);
        chk("t5_ovf_sticky", 128'(overflow_err), 128'(1));

        // empty tile
        start_tile(0, 0);
        chk("t6_zero_done", 128'(drain_done), 128'(1));
        chk("t6_zero_tvalid", 128'(m_axis_tvalid), 128'(0));
        @(negedge clk);
        chk("t6_zero_pulse", 128'(drain_done), 128'(0));
        chk("t6_zero_idle", 128'(drain_busy), 128'(0));

        // reset while flushing
        mode = 0;
        acc_pat = '{5, 6, 7, 8};
        exp_pat = '{5, 6, 7, 8};
        m_axis_tready = 1'b0;
        start_tile(4, 0);
        for (int i = 0; i < 4; i++) begin
            acc_valid = 1'b1;
            acc_data  = row_acc(i);
            @(negedge clk);
        end
        acc_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_pre_busy", 128'(drain_busy), 128'(1));
        chk("t6_pre_tvalid", 128'(m_axis_tvalid), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("t6_rst_tvalid", 128'(m_axis_tvalid), 128'(0));
        chk("t6_rst_tdata", 128'(m_axis_tdata), 128'(0));
        chk("t6_rst_tlast", 128'(m_axis_tlast), 128'(0));
        chk("t6_rst_busy", 128'(drain_busy), 128'(0));
        chk("t6_rst_ovf", 128'(overflow_err), 128'(0));
        chk("t6_rst_ready", 128'(acc_ready), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        m_axis_tready = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_post_tvalid", 128'(m_axis_tvalid), 128'(0));

        // fresh tile after reset sees only new data
        acc_pat = '{-3, 300, 9, -200};
        exp_pat = '{-3, 127, 9, -128};
        run_tile("t6_after", 1, 0, 0, 1'b0, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
